dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined CPU: the target end of the CPU's load/store port. It accepts one word-addressed request at a time from the MEM stage, inserts a programmable number of wait states, and then completes the request. A write is committed with byte lanes; a read returns a 32-bit word. `busy` feeds the pipeline stall logic, so the CPU holds MEM/WB until `ready` pulses.

## Interface
Parameters:
- `DEPTH`, 32: number of 32-bit words implemented; valid addresses are 0..DEPTH-1.
- `ADDR_W`, 5: word-address width; requires DEPTH ≤ 2^ADDR_W.
- `WAIT`, 2: wait-state cycles inserted before the response; valid range 0..15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 1: request strobe from the MEM stage; sampled only in IDLE.
- `we` input 1: 1 = write, 0 = read; captured with `req`.
- `addr` input ADDR_W: word address; captured with `req`.
- `wdata` input 32: write data; captured with `req`.
- `be` input 4: byte enables, bit i = byte lane [8i+7:8i]; captured with `req`.
- `ready` output 1: one-cycle completion pulse.
- `rdata` output 32: read data; valid with `ready` for reads.
- `err` output 1: pulses with `ready` when the captured address is ≥ DEPTH.
- `busy` output 1: high whenever the state is not IDLE; drives the CPU stall.

## Operation
- FSM has three states.
  - IDLE: if `req`=1, capture `we`, `addr`, `wdata` and `be`. Go to WAIT if WAIT>0 (load `cnt`=WAIT-1), otherwise go straight to RESP.
  - WAIT: if `cnt`=0 go to RESP, else decrement `cnt`.
  - RESP: `ready`=1 for this cycle only; always return to IDLE next.
- Inputs are ignored outside IDLE. There is no queue; a `req` held high through RESP is accepted again in the following IDLE cycle.
- Write, in-range address: at the RESP edge, each lane with `be[i]`=1 takes the captured `wdata` lane; other lanes are unchanged. `be`=0 completes normally as a no-op. `rdata` is unchanged.
- Read, in-range address: `rdata` is the full word `mem[addr]`, registered so it is valid during the RESP cycle. `be` is ignored.
- Out of range (captured `addr` ≥ DEPTH): no write occurs; `rdata`=0 for reads; `err`=1 during RESP.
- `rdata` holds its last read value until the next read response.
- Storage is a DEPTH×32 register array. Reset clears every word to 0.

## Timing
- Reset values: state IDLE, `cnt` 0, `ready` 0, `err` 0, `busy` 0, `rdata` 0, all memory words 0.
- A request accepted at edge k (`req`=1 in IDLE during cycle k):
  - cycles k+1..k+WAIT are WAIT;
  - cycle k+WAIT+1 is RESP with `ready`=1;
  - cycle k+WAIT+2 is IDLE.
- Latency is WAIT+1 cycles. Maximum throughput is one access per WAIT+2 cycles.
- `busy` is registered state decode: 0 in cycle k, 1 from k+1 through RESP, 0 again in IDLE.
- Read-after-write: a read accepted after the write's `ready` cycle returns the updated data.
- Reset asserted in any state takes effect at that edge. Any pending write is discarded, and `ready`, `err` and `busy` read 0 the next cycle. Reset has priority over `req`.
- `req` asserted in the same cycle as `ready` (state RESP) is not accepted. It is accepted one cycle later if still high.

## Test plan
- Reset, then read addr 5 with WAIT=2 (accept at edge k) -> `busy` high in k+1..k+3, `ready` only in k+3, `rdata`=0x00000000, `err`=0.
- Write addr 3, `wdata`=0xDEADBEEF, `be`=4'b1111, then read addr 3 -> `rdata`=0xDEADBEEF. Then write 0x11223344 with `be`=4'b0101 and read again -> `rdata`=0xDE22BE44.
- Read addr 40 with ADDR_W=6, DEPTH=32 -> `ready`+`err` pulse together, `rdata`=0. A write to addr 40 leaves all words unchanged (spot-check words 0 and 8).
- `req` held high for 10 cycles, WAIT=2, read addr 0 -> exactly 2 `ready` pulses, at k+3 and k+7. No acceptance in WAIT or RESP.
- Write 0xCAFEF00D to addr 7, with `rst` asserted during the WAIT cycle after accept -> next cycle `busy`=0 and `ready` never pulses. A subsequent read of addr 7 returns 0.
- WAIT=0: read accepted at edge k -> `ready` at k+1. A back-to-back `req` is accepted at k+2, so `ready` pulses every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU load/store port: accepts one request,
// inserts WAIT wait states, then pulses ready with byte-lane write or read data.
module dmem_responder #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic              ready,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT - 1);
  localparam bit          NO_WAIT   = (WAIT == 32'sd0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [3:0]          be_r;
  logic [31:0]         mem_r [DEPTH];
  logic                ready_r;
  logic                err_r;
  logic                busy_r;
  logic [31:0]         rdata_r;

  logic                acc_we_s;
  logic [ADDR_W-1:0]   acc_addr_s;
  logic [31:0]         acc_wdata_s;
  logic [3:0]          acc_be_s;
  logic                in_range_s;
  logic                go_resp_s;
  logic [IDX_W-1:0]    idx_s;

  // Request fields for the response edge: live inputs when going straight from IDLE, else the captured copy
  always_comb begin
    acc_we_s    = we_r;
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_be_s    = be_r;
    if (state_r == ST_IDLE) begin
      acc_we_s    = we;
      acc_addr_s  = addr;
      acc_wdata_s = wdata;
      acc_be_s    = be;
    end else begin
      acc_we_s    = we_r;
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_be_s    = be_r;
    end
    in_range_s = (32'(acc_addr_s) < DEPTH_U);
    idx_s      = acc_addr_s[IDX_W-1:0];
    go_resp_s  = ((state_r == ST_IDLE) && req && NO_WAIT) ||
                 ((state_r == ST_WAIT) && (cnt_r == 4'd0));
  end

  // Request FSM, storage array and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      rdata_r <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      if (go_resp_s) begin
        // Memory is updated on the edge entering RESP so rdata is valid alongside ready
        state_r <= ST_RESP;
        ready_r <= 1'b1;
        err_r   <= !in_range_s;
        busy_r  <= 1'b1;
        if (in_range_s) begin
          if (acc_we_s) begin
            for (int l = 0; l < 4; l++) begin
              if (acc_be_s[l]) begin
                mem_r[idx_s][8*l +: 8] <= acc_wdata_s[8*l +: 8];
              end
            end
          end else begin
            rdata_r <= mem_r[idx_s];
          end
        end else if (!acc_we_s) begin
          rdata_r <= 32'd0;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (req) begin
              we_r    <= we;
              addr_r  <= addr;
              wdata_r <= wdata;
              be_r    <= be;
              cnt_r   <= WAIT_LOAD;
              state_r <= ST_WAIT;
              busy_r  <= 1'b1;
            end
          end
          ST_WAIT: cnt_r <= cnt_r - 4'd1;
          ST_RESP: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready = ready_r;
  assign err   = err_r;
  assign busy  = busy_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance with a 6-bit address
// (for out-of-range access) and a WAIT=0 instance for back-to-back timing.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_a, we_a, ready_a, err_a, busy_a;
  logic [5:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic [3:0]  be_a;

  logic        req_z, we_z, ready_z, err_z, busy_z;
  logic [4:0]  addr_z;
  logic [31:0] wdata_z, rdata_z;
  logic [3:0]  be_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(32), .ADDR_W(6), .WAIT(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .be(be_a), .ready(ready_a), .rdata(rdata_a),
    .err(err_a), .busy(busy_a)
  );

  dmem_responder #(.DEPTH(32), .ADDR_W(5), .WAIT(0)) u_dut_z (
    .clk(clk), .rst(rst), .req(req_z), .we(we_z), .addr(addr_z),
    .wdata(wdata_z), .be(be_z), .ready(ready_z), .rdata(rdata_z),
    .err(err_z), .busy(busy_z)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access on the WAIT=2 instance, checking busy/ready timing cycle by cycle
  task automatic access_a(input string tag, input logic w, input logic [5:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          output logic [31:0] rd, output logic er);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; be_a = b;
    check_eq({tag, "_busy_k"}, 32'(busy_a), 32'd0);
    step();
    req_a = 1'b0;
    rd = 32'd0;
    er = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check_eq($sformatf("%s_busy_k%0d", tag, c), 32'(busy_a), 32'd1);
      check_eq($sformatf("%s_ready_k%0d", tag, c), 32'(ready_a), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) begin
        rd = rdata_a;
        er = err_a;
      end
      step();
    end
    check_eq({tag, "_busy_after"}, 32'(busy_a), 32'd0);
    check_eq({tag, "_ready_after"}, 32'(ready_a), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [9:0]  mask_a;
    logic [5:0]  mask_z;
    logic        seen;

    rst = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = 6'd0; wdata_a = 32'd0; be_a = 4'd0;
    req_z = 1'b0; we_z = 1'b0; addr_z = 5'd0; wdata_z = 32'd0; be_z = 4'd0;
    repeat (3) step();
    rst = 1'b0;
    check_eq("rst_ready", 32'(ready_a), 32'd0);
    check_eq("rst_err", 32'(err_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_rdata", rdata_a, 32'd0);
    check_eq("rst_busy_z", 32'(busy_z), 32'd0);
    check_eq("rst_ready_z", 32'(ready_z), 32'd0);

    // Basic read after reset
    access_a("rd5", 1'b0, 6'd5, 32'd0, 4'hF, rd, er);
    check_eq("rd5_data", rd, 32'h0000_0000);
    check_eq("rd5_err", 32'(er), 32'd0);

    // Full-word write, then partial-lane write
    access_a("wr3", 1'b1, 6'd3, 32'hDEAD_BEEF, 4'b1111, rd, er);
    check_eq("wr3_err", 32'(er), 32'd0);
    access_a("rd3a", 1'b0, 6'd3, 32'd0, 4'b0000, rd, er);
    check_eq("rd3a_data", rd, 32'hDEAD_BEEF);
    access_a("wr3b", 1'b1, 6'd3, 32'h1122_3344, 4'b0101, rd, er);
    check_eq("wr3b_rdata_hold", rd, 32'hDEAD_BEEF);
    access_a("rd3b", 1'b0, 6'd3, 32'd0, 4'b0000, rd, er);
    check_eq("rd3b_data", rd, 32'hDE22_BE44);

    // Out of range: address 40 would alias word 8 if the range check were missing
    access_a("wr8", 1'b1, 6'd8, 32'h5A5A_5A5A, 4'b1111, rd, er);
    check_eq("wr8_rdata_hold", rd, 32'hDE22_BE44);
    access_a("rd40", 1'b0, 6'd40, 32'd0, 4'b1111, rd, er);
    check_eq("rd40_data", rd, 32'd0);
    check_eq("rd40_err", 32'(er), 32'd1);
    access_a("wr40", 1'b1, 6'd40, 32'hFFFF_FFFF, 4'b1111, rd, er);
    check_eq("wr40_err", 32'(er), 32'd1);
    access_a("rd0", 1'b0, 6'd0, 32'd0, 4'b0000, rd, er);
    check_eq("rd0_data", rd, 32'd0);
    access_a("rd8", 1'b0, 6'd8, 32'd0, 4'b0000, rd, er);
    check_eq("rd8_data", rd, 32'h5A5A_5A5A);
    check_eq("rd8_err", 32'(er), 32'd0);

    // req held for 10 cycles: accepts at k and k+4, ready at k+3 and k+7
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd0; be_a = 4'd0;
    mask_a = 10'd0;
    for (int i = 0; i < 10; i++) begin
      mask_a[i] = ready_a;
      step();
    end
    req_a = 1'b0;
    check_eq("hold_ready_mask", 32'(mask_a), 32'h0000_0088);
    // third acceptance happened at k+8; it completes at k+11
    check_eq("hold_ready_k11", 32'(ready_a), 32'd0);
    step();
    check_eq("hold_ready_k11b", 32'(ready_a), 32'd1);
    step();
    check_eq("hold_busy_end", 32'(busy_a), 32'd0);

    // Reset in the WAIT cycle discards a pending write
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'd7; wdata_a = 32'hCAFE_F00D; be_a = 4'b1111;
    step();
    req_a = 1'b0;
    check_eq("rstw_busy_k1", 32'(busy_a), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rstw_busy", 32'(busy_a), 32'd0);
    check_eq("rstw_ready", 32'(ready_a), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | ready_a;
      step();
    end
    check_eq("rstw_no_ready", 32'(seen), 32'd0);
    access_a("rd7", 1'b0, 6'd7, 32'd0, 4'b0000, rd, er);
    check_eq("rd7_data", rd, 32'd0);

    // WAIT=0 instance: single write, then back-to-back reads
    req_z = 1'b1; we_z = 1'b1; addr_z = 5'd2; wdata_z = 32'h1357_9BDF; be_z = 4'b1111;
    step();
    req_z = 1'b0;
    check_eq("z_wr_ready", 32'(ready_z), 32'd1);
    check_eq("z_wr_busy", 32'(busy_z), 32'd1);
    step();
    check_eq("z_wr_ready_off", 32'(ready_z), 32'd0);
    check_eq("z_wr_busy_off", 32'(busy_z), 32'd0);
    req_z = 1'b1; we_z = 1'b0; addr_z = 5'd2;
    mask_z = 6'd0;
    for (int i = 0; i < 6; i++) begin
      mask_z[i] = ready_z;
      if (i == 1) check_eq("z_rd_data", rdata_z, 32'h1357_9BDF);
      step();
    end
    req_z = 1'b0;
    check_eq("z_ready_mask", 32'(mask_z), 32'h0000_002A);
    step();
    check_eq("z_busy_end", 32'(busy_z), 32'd0);
    check_eq("z_err", 32'(err_z), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
